jpeg_frame_buffer: RTL and testbench

- Sits downstream of the AXI-Stream JPEG encoder top and consumes its 32-bit encoded-data stream.
- Stores one compressed frame in an internal word-addressed RAM.
- Detects the EOI marker (FF D9) to report the exact byte length of the frame.
- Provides a 1-cycle-latency read port so a host or APB bridge can read the frame back.

---
 rtl/jpeg_frame_buffer.sv | 189 ++++++++++++++++++
 tb/tb_jpeg_frame_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_frame_buffer.sv
// jpeg_frame_buffer: captures one JPEG-encoded frame from a 32-bit
// AXI-Stream into a word-addressed RAM, reports its exact byte length by
// locating the FF D9 end-of-image marker, and offers a 1-cycle-latency
// read port. Byte order of a stream word is b0=[7:0] .. b3=[31:24].
module jpeg_frame_buffer #(
  parameter int DEPTH_WORDS = 16384,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          eoi_missing,
  output logic [AW+2:0] image_size
);

  localparam int SW = AW + 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LAST_IDX  = (AW+1)'(DEPTH_WORDS - 1);
  localparam logic [SW-1:0] FULL_SIZE = SW'(4 * DEPTH_WORDS);
  localparam logic [SW-1:0] WORD_SIZE = SW'(4);
  localparam logic [SW-1:0] SIZE_ONE  = SW'(1);

  // Returns {found, k} for the smallest byte lane k that holds D9 with FF
  // immediately before it in stream order; lane 0 looks back at the last
  // byte of the previous word.
  function automatic logic [2:0] find_eoi(input logic [31:0] word,
                                          input logic [7:0]  prev);
    logic [39:0] seq;
    logic [2:0]  res;
    seq = {word, prev};
    res = 3'b000;
    // Scan downward so the lowest matching lane is the one kept.
    for (int i = 3; i >= 0; i--) begin
      if (seq[8*i +: 8] == 8'hFF && seq[8*i+8 +: 8] == 8'hD9) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [AW:0]   wr_ptr;
  logic [7:0]    prev_byte;
  logic          accept;
  logic          wr_en;
  logic          capture_end;
  logic          drain_end;
  logic          capture_full;
  logic [2:0]    eoi;
  logic          eoi_found;
  logic [1:0]    eoi_lane;
  logic [SW-1:0] size_base;
  logic [SW-1:0] size_frame;

  logic [31:0]   mem [DEPTH_WORDS];

  assign s_axis_tready = (state == ST_CAPTURE) || (state == ST_DRAIN);
  assign busy          = s_axis_tready;
  assign done          = (state == ST_DONE);

  assign accept = s_axis_tvalid & s_axis_tready;

  // A start in the same cycle as an accept aborts the frame, so the
  // accepted word and its tlast are both thrown away.
  assign wr_en        = accept & ~start & (state == ST_CAPTURE);
  assign capture_end  = wr_en & s_axis_tlast;
  assign capture_full = wr_en & ~s_axis_tlast & (wr_ptr == LAST_IDX);
  assign drain_end    = accept & ~start & (state == ST_DRAIN) & s_axis_tlast;

  assign eoi       = find_eoi(s_axis_tdata, prev_byte);
  assign eoi_found = eoi[2];
  assign eoi_lane  = eoi[1:0];

  // wr_ptr is the index of the current word, so 4*N is the byte offset of
  // its first byte; a missing marker counts the whole last word.
  assign size_base  = {wr_ptr, 2'b00};
  assign size_frame = eoi_found ? (size_base + SW'(eoi_lane) + SIZE_ONE)
                                : (size_base + WORD_SIZE);

  // Next-state selection; start restarts capture from any state.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ST_CAPTURE;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_IDLE;
        ST_CAPTURE: begin
          if (capture_end) begin
            state_next = ST_DONE;
          end else if (capture_full) begin
            state_next = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_end) begin
            state_next = ST_DONE;
          end
        end
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write pointer and the carried-over last byte used for split markers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      prev_byte <= 8'h00;
    end else if (start) begin
      wr_ptr    <= '0;
      prev_byte <= 8'h00;
    end else if (wr_en) begin
      wr_ptr    <= wr_ptr + PTR_ONE;
      prev_byte <= s_axis_tdata[31:24];
    end
  end

  // Sticky frame results, updated only on completion, start or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow    <= 1'b0;
      eoi_missing <= 1'b0;
      image_size  <= '0;
    end else if (start) begin
      overflow    <= 1'b0;
      eoi_missing <= 1'b0;
      image_size  <= '0;
    end else if (capture_end) begin
      overflow    <= 1'b0;
      eoi_missing <= ~eoi_found;
      image_size  <= size_frame;
    end else if (drain_end) begin
      overflow    <= 1'b1;
      eoi_missing <= 1'b0;
      image_size  <= FULL_SIZE;
    end
  end

  // RAM write port; words past capacity never reach here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    end
  end

  // Registered read port; reading the address being written returns the
  // old word, and rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= 32'h0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_jpeg_frame_buffer.sv
// Self-checking bench for jpeg_frame_buffer with a 4-word RAM: a table of
// frames run through a common capture/readback routine, plus hand-written
// sequences for abort, start/tlast collision, read-before-write and reset.
module tb_jpeg_frame_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          eoi_missing;
  logic [AW+2:0] image_size;

  always #5 clk = ~clk;

  jpeg_frame_buffer #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .overflow(overflow), .eoi_missing(eoi_missing),
    .image_size(image_size)
  );

  typedef struct {
    int               n;
    logic [5:0][31:0] w;
    logic [31:0]      size;
    logic             ovf;
    logic             miss;
  } frame_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  frame_t      tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_spurious: got rd_valid=1 with data %h expected no read", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_read(input int addr);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    exp_q.push_back(model[addr]);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic read_all(input int n);
    for (int a = 0; a < n; a++) do_read(a);
    tick();
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input int idx);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    check("tready_capture", {31'd0, s_axis_tready}, 32'd1);
    tick();
    if (idx < DEPTH) model[idx] = d;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] size,
                              input logic ovf, input logic miss);
    check({tag, "_done"},     {31'd0, done},        32'd1);
    check({tag, "_busy"},     {31'd0, busy},        32'd0);
    check({tag, "_tready"},   {31'd0, s_axis_tready}, 32'd0);
    check({tag, "_size"},     32'(image_size),      size);
    check({tag, "_overflow"}, {31'd0, overflow},    {31'd0, ovf});
    check({tag, "_eoi_miss"}, {31'd0, eoi_missing}, {31'd0, miss});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},     {31'd0, busy},     32'd1);
    check({tag, "_done"},     {31'd0, done},     32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_eoi_miss"}, {31'd0, eoi_missing}, 32'd0);
    check({tag, "_size"},     32'(image_size),   32'd0);
  endtask

  task automatic run_frame(input int id, input frame_t f);
    string tag;
    tag = $sformatf("frame%0d", id);
    pulse_start();
    check_cleared({tag, "_start"});
    for (int i = 0; i < f.n; i++) begin
      check({tag, "_busy_during"}, {31'd0, busy}, 32'd1);
      send_word(f.w[i], (i == f.n - 1), i);
    end
    check_result(tag, f.size, f.ovf, f.miss);
    read_all((f.n < DEPTH) ? f.n : DEPTH);
  endtask

  function automatic frame_t mk(input int n, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [31:0] w4, input logic [31:0] w5,
                                input logic [31:0] size, input logic ovf, input logic miss);
    frame_t f;
    f.n = n;
    f.w = {w5, w4, w3, w2, w1, w0};
    f.size = size;
    f.ovf = ovf;
    f.miss = miss;
    return f;
  endfunction

  initial begin
    // EOI in lane 2 of word 2: 4*2+3 = 11.
    tbl[0] = mk(3, 32'h0000D8FF, 32'h11223344, 32'h00D9FFAA, 0, 0, 0, 32'd11, 1'b0, 1'b0);
    // FF in b3 of word 0, D9 in b0 of word 1: 4*1+1 = 5.
    tbl[1] = mk(2, 32'hFF000000, 32'h000000D9, 0, 0, 0, 0, 32'd5, 1'b0, 1'b0);
    // No marker; last byte FF sets up the next frame's prev_byte test.
    tbl[2] = mk(2, 32'h01020304, 32'hFF060708, 0, 0, 0, 0, 32'd8, 1'b0, 1'b1);
    // Single word with D9 in b0: prev_byte must be 0 after start, so no EOI.
    tbl[3] = mk(1, 32'h123456D9, 0, 0, 0, 0, 0, 32'd4, 1'b0, 1'b1);
    // Exact fit: tlast on the last RAM word, EOI in lane 3: 4*3+4 = 16.
    tbl[4] = mk(4, 32'h01010101, 32'h02020202, 32'h03030303, 32'hD9FF0000, 0, 0,
                32'd16, 1'b0, 1'b0);
    // Overflow: 6 words into 4, last two discarded in DRAIN.
    tbl[5] = mk(6, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004,
                32'hA0000005, 32'hA0000006, 32'd16, 1'b1, 1'b0);

    reset = 1'b1; start = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; rd_en = 1'b0; rd_addr = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state.
    check("rst_tready",   {31'd0, s_axis_tready}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid},      32'd0);
    check("rst_busy",     {31'd0, busy},          32'd0);
    check("rst_done",     {31'd0, done},          32'd0);
    check("rst_overflow", {31'd0, overflow},      32'd0);
    check("rst_eoi_miss", {31'd0, eoi_missing},   32'd0);
    check("rst_size",     32'(image_size),        32'd0);
    check("rst_rd_data",  rd_data,                32'd0);

    // IDLE ignores traffic.
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'($urandom_range(0, 1));
      s_axis_tdata  = $urandom;
      s_axis_tlast  = 1'($urandom_range(0, 1));
      check("idle_tready", {31'd0, s_axis_tready}, 32'd0);
      tick();
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;

    for (int t = 0; t < 6; t++) run_frame(t, tbl[t]);

    // DONE ignores traffic and leaves the RAM alone.
    for (int i = 0; i < 6; i++) begin
      s_axis_tvalid = 1'($urandom_range(0, 1));
      s_axis_tdata  = $urandom;
      s_axis_tlast  = 1'($urandom_range(0, 1));
      check("done_tready", {31'd0, s_axis_tready}, 32'd0);
      tick();
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    read_all(DEPTH);

    // rd_data holds after the read completes.
    do_read(2);
    tick(); tick();
    check("rd_hold", rd_data, model[2]);

    // Abort in DRAIN: wr_ptr must restart at 0 (size 2, not 4*N+2).
    pulse_start();
    for (int i = 0; i < 5; i++) send_word(32'hB0000001 + 32'(i), 1'b0, i);
    check("drain_busy", {31'd0, busy}, 32'd1);
    pulse_start();
    check_cleared("abort");
    check("abort_tready", {31'd0, s_axis_tready}, 32'd1);
    send_word(32'h0000D9FF, 1'b1, 0);
    check_result("abort_frame", 32'd2, 1'b0, 1'b0);

    // start together with a tlast accept: word dropped, capture restarts.
    pulse_start();
    send_word(32'h11111111, 1'b0, 0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h22222222; s_axis_tlast = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    check_cleared("collide");
    send_word(32'h33333333, 1'b1, 0);
    check_result("collide_frame", 32'd4, 1'b0, 1'b1);
    read_all(2);

    // Read and write of the same address in one cycle return the old word.
    pulse_start();
    rd_en = 1'b1; rd_addr = '0;
    exp_q.push_back(model[0]);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hCAFEF00D; s_axis_tlast = 1'b1;
    tick();
    model[0] = 32'hCAFEF00D;
    rd_en = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    check_result("rbw_frame", 32'd4, 1'b0, 1'b1);
    read_all(1);

    // Reset mid-capture, then traffic before start must not be taken.
    pulse_start();
    send_word(32'h44444444, 1'b0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_tready",   {31'd0, s_axis_tready}, 32'd0);
    check("mrst_rd_valid", {31'd0, rd_valid},      32'd0);
    check("mrst_busy",     {31'd0, busy},          32'd0);
    check("mrst_done",     {31'd0, done},          32'd0);
    check("mrst_size",     32'(image_size),        32'd0);
    check("mrst_rd_data",  rd_data,                32'd0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h55555555; s_axis_tlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mrst_idle_tready", {31'd0, s_axis_tready}, 32'd0);
      tick();
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    pulse_start();
    send_word(32'hD9FF0000, 1'b1, 0);
    check_result("post_reset", 32'd4, 1'b0, 1'b0);
    read_all(1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
